kasumi_round_sched: RTL and testbench

KASUMI_ROUND_SCHED -- requirements
Module: kasumi_round_sched

---
 rtl/kasumi_pkg.sv | 22 ++
 rtl/kasumi_lat_cnt.sv | 28 ++
 rtl/kasumi_round_sched.sv | 127 ++++++++++++
 tb/tb_kasumi_round_sched.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/kasumi_pkg.sv
// KASUMI round scheduler shared types and sizes.
// Used by kasumi_round_sched and kasumi_lat_cnt.
package kasumi_pkg;

    localparam int NUM_ROUNDS = 8;
    localparam int HALF_W     = 32;
    localparam int BLK_W      = 64;
    localparam int IDX_W      = 3;
    localparam int CNT_W      = 3;
    localparam int BCNT_W     = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_RND = IDX_W'(NUM_ROUNDS - 1);

endpackage

// File: rtl/kasumi_lat_cnt.sv
// Loadable down-counter with zero flag.
// Times the wait for the external round datapath.
module kasumi_lat_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/kasumi_round_sched.sv
// KASUMI 8-round Feistel scheduler around an external round datapath.
// Optional block counter: define KASUMI_SCHED_BLKCNT_EN.
module kasumi_round_sched
    import kasumi_pkg::*;
#(
    parameter int RND_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BLK_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BLK_W-1:0]  out_data,
    output logic [HALF_W-1:0] rnd_in,
    output logic              rnd_odd,
    output logic [IDX_W-1:0]  rnd_idx,
    input  logic [HALF_W-1:0] rnd_out,
    output logic              busy,
    output logic [BCNT_W-1:0] blk_cnt
);

    localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(RND_LAT - 1);

    state_t             r_state;
    state_t             w_nxt;
    logic [HALF_W-1:0]  r_l;
    logic [HALF_W-1:0]  r_r;
    logic [IDX_W-1:0]   r_idx;
    logic               w_zero;
    logic               w_load;
    logic               w_dec;
    logic               w_in_hs;
    logic               w_out_hs;

    assign w_in_hs  = (r_state == S_IDLE) && in_valid;
    assign w_out_hs = (r_state == S_DONE) && out_ready;
    assign w_load   = (r_state == S_ISSUE);
    assign w_dec    = (r_state == S_WAIT);

    kasumi_lat_cnt #(
        .W (CNT_W)
    ) u_lat_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_val  (LAT_LD),
        .i_dec  (w_dec),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (in_valid) w_nxt = S_ISSUE;
            S_ISSUE:  w_nxt = S_WAIT;
            S_WAIT:   if (w_zero) w_nxt = S_UPDATE;
            S_UPDATE: w_nxt = (r_idx == LAST_RND) ? S_DONE : S_ISSUE;
            S_DONE:   if (out_ready) w_nxt = S_IDLE;
            default:  w_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        unique case (1'b1)
            (r_state == S_IDLE): begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            (r_state == S_DONE): out_valid = 1'b1;
            default: ;
        endcase
    end

    // Halves only move on acceptance and UPDATE, so rnd_* hold for the whole round.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_l   <= '0;
            r_r   <= '0;
            r_idx <= '0;
        end else if (w_in_hs) begin
            r_l   <= in_data[BLK_W-1:HALF_W];
            r_r   <= in_data[HALF_W-1:0];
            r_idx <= '0;
        end else if (r_state == S_UPDATE) begin
            r_l <= r_r ^ rnd_out;
            r_r <= r_l;
            if (r_idx != LAST_RND) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign out_data = {r_l, r_r};
    assign rnd_in   = r_l;
    assign rnd_odd  = ~r_idx[0];
    assign rnd_idx  = r_idx;

`ifdef KASUMI_SCHED_BLKCNT_EN
    logic [BCNT_W-1:0] r_blk_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blk_cnt <= '0;
        end else if (w_out_hs && (r_blk_cnt != '1)) begin
            r_blk_cnt <= r_blk_cnt + 1'b1;
        end
    end

    assign blk_cnt = r_blk_cnt;
`else
    assign blk_cnt = '0;
`endif

endmodule

// File: tb/tb_kasumi_round_sched.sv
// Randomized bench for kasumi_round_sched at RND_LAT 2, 1 and 7.
// Reference is a plain software Feistel loop with rnd_out = rnd_in ^ idx.
module tb_kasumi_round_sched;

    logic        clk = 1'b0;
    logic        rst;
    int          n_chk = 0;
    int          n_fail = 0;
    int          hs_cnt [3];

    logic        iv   [3];
    logic        ir   [3];
    logic [63:0] idat [3];
    logic        ov   [3];
    logic        ordy [3];
    logic [63:0] odat [3];
    logic [31:0] rin  [3];
    logic        rodd [3];
    logic [2:0]  ridx [3];
    logic [31:0] rout [3];
    logic        bsy  [3];
    logic [15:0] bc   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
        kasumi_round_sched #(.RND_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_data   (idat[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_data  (odat[g]),
            .rnd_in    (rin[g]),
            .rnd_odd   (rodd[g]),
            .rnd_idx   (ridx[g]),
            .rnd_out   (rout[g]),
            .busy      (bsy[g]),
            .blk_cnt   (bc[g])
        );
        assign rout[g] = rin[g] ^ {29'b0, ridx[g]};
    end

    function automatic int lat_of(input int d);
        if (d == 0) return 2;
        if (d == 1) return 1;
        return 7;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_cnt();
        for (int d = 0; d < 3; d++) begin
`ifdef KASUMI_SCHED_BLKCNT_EN
            chk("blk_cnt", 64'(bc[d]), 64'(hs_cnt[d]));
`else
            chk("blk_cnt0", 64'(bc[d]), 64'd0);
`endif
        end
    endtask

    // One block on instance d; caller is at a negedge.
    task automatic run_block(input int d, input logic [63:0] din,
                             input int hold);
        logic [31:0] rl [8];
        logic [31:0] l, r, t;
        logic [63:0] held;
        int lt, lat, errs, j, rn;
        lt = lat_of(d);
        l = din[63:32];
        r = din[31:0];
        for (int i = 0; i < 8; i++) begin
            rl[i] = l;
            t = r ^ (l ^ 32'(i));
            r = l;
            l = t;
        end
        j = 0;
        while (!ir[d] && j < 100) begin
            @(negedge clk);
            j++;
        end
        chk("rdy_wait", 64'(ir[d]), 64'd1);
        iv[d] = 1'b1;
        idat[d] = din;
        lat = 0;
        errs = 0;
        for (int c = 1; c <= 8 * (lt + 2) + 10; c++) begin
            @(negedge clk);
            if (c == 1) iv[d] = 1'b0;
            if (ov[d]) begin
                lat = c;
                break;
            end
            if (c <= 8 * (lt + 2)) begin
                rn = (c - 1) / (lt + 2);
                if (rin[d] !== rl[rn] || ridx[d] !== rn[2:0] ||
                    rodd[d] !== ~rn[0] || bsy[d] !== 1'b1 ||
                    ir[d] !== 1'b0)
                    errs++;
            end
        end
        chk("latency", 64'(lat), 64'(8 * (lt + 2) + 1));
        chk("trace", 64'(errs), 64'd0);
        chk("out_data", odat[d], {l, r});
        held = odat[d];
        errs = 0;
        for (int h = 0; h < hold; h++) begin
            iv[d] = 1'b1;
            idat[d] = ~din;
            @(negedge clk);
            if (!ov[d] || odat[d] !== held || ir[d] !== 1'b0) errs++;
        end
        iv[d] = 1'b0;
        if (hold > 0) chk("hold", 64'(errs), 64'd0);
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
        hs_cnt[d]++;
        chk("post_ov", 64'(ov[d]), 64'd0);
        chk("post_rdy", 64'(ir[d]), 64'd1);
    endtask

    task automatic chk_reset_vals(input int d);
        chk("rst_ov", 64'(ov[d]), 64'd0);
        chk("rst_busy", 64'(bsy[d]), 64'd0);
        chk("rst_rdy", 64'(ir[d]), 64'd1);
        chk("rst_rin", 64'(rin[d]), 64'd0);
        chk("rst_odd", 64'(rodd[d]), 64'd1);
        chk("rst_idx", 64'(ridx[d]), 64'd0);
        chk("rst_data", odat[d], 64'd0);
        chk("rst_bc", 64'(bc[d]), 64'd0);
    endtask

    task automatic reset_mid(input logic [63:0] din);
        int errs;
        errs = 0;
        iv[0] = 1'b1;
        idat[0] = din;
        for (int c = 1; c <= 4 * 4 + 2; c++) begin
            @(negedge clk);
            if (c == 1) iv[0] = 1'b0;
            if (ov[0]) errs++;
        end
        chk("mid_ridx", 64'(ridx[0]), 64'd4);
        rst = 1'b0;
        #1;
        chk_reset_vals(0);
        @(negedge clk);
        if (ov[0]) errs++;
        chk("mid_no_ov", 64'(errs), 64'd0);
        rst = 1'b1;
        for (int d = 0; d < 3; d++) hs_cnt[d] = 0;
    endtask

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0;
            ordy[d] = 1'b0;
            idat[d] = '0;
            hs_cnt[d] = 0;
        end
        repeat (2) @(negedge clk);
        chk_reset_vals(0);
        rst = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", 64'(ir[0]), 64'd1);

        run_block(0, 64'h0123456789ABCDEF, 0);
        run_block(0, {$urandom, $urandom}, 10);
        run_block(0, {$urandom, $urandom}, 0);
        chk_cnt();

        reset_mid({$urandom, $urandom});
        run_block(0, {$urandom, $urandom}, 0);
        chk_cnt();

        for (int k = 0; k < 2; k++) begin
            run_block(1, {$urandom, $urandom}, $urandom_range(0, 3));
            run_block(2, {$urandom, $urandom}, $urandom_range(0, 3));
        end
        for (int k = 0; k < 4; k++) begin
            run_block(0, {$urandom, $urandom}, $urandom_range(0, 4));
        end
        chk_cnt();

`ifdef KASUMI_SCHED_BLKCNT_EN
        force g_dut[0].u_dut.r_blk_cnt = 16'hFFFF;
        @(negedge clk);
        release g_dut[0].u_dut.r_blk_cnt;
        run_block(0, {$urandom, $urandom}, 0);
        chk("blk_sat", 64'(bc[0]), 64'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
